exe_div_unit: RTL and testbench
===============================

# exe_div_unit

Iterative 32-bit integer divider in the execute stage, fed each cycle by the decode/execute pipeline register. On a divide instruction it computes quotient and remainder over 32 cycles, one bit per cycle, and holds the pipeline through `stall_div`, which the hazard unit ORs into `stallE`. Results go to the HI/LO write path (`hilowriteE`) in the cycle the stall drops.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the logic only needs to support 32.
- `CNT_W`, 6: iteration counter width; must hold `WIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous abort; the execute-stage flush.
- `start` in 1: a divide instruction is in E; held high while that instruction stays in E.
- `signed_div` in 1: 1 = DIV, 0 = DIVU; sampled with `start`.
- `srca` in 32: dividend (rs), sampled with `start`.
- `srcb` in 32: divisor (rt), sampled with `start`.
- `stall_div` out 1: hold F/D/E; combinational from state and `start`.
- `busy` out 1: the FSM is in BUSY (registered).
- `result_valid` out 1: one-cycle pulse; `hi`/`lo` are final.
- `hi` out 32: remainder.
- `lo` out 32: quotient.

## Operation
- FSM states are IDLE, BUSY and DONE.
  - IDLE: if `start` is high, latch the operand magnitudes, the sign flags and the zero-divisor flag; set the counter to 32; go to BUSY.
  - BUSY: one restoring step per cycle.
    - Shift {rem, quo} left by 1 and trial-subtract the divisor magnitude from the upper 33 bits.
    - If the result is non-negative, keep it and set quo[0]=1; otherwise quo[0]=0.
    - Decrement the counter. When the counter is 1 at the edge, go to DONE.
  - DONE: `hi`/`lo` hold final values and `result_valid`=1. Go unconditionally to IDLE at the next edge. `start` is ignored in DONE, because the same instruction is still in E.
- `stall_div` = (IDLE && `start`) || BUSY. It is 0 in DONE, so the pipeline advances and the divide leaves E.
- Sign fixup is applied on the DONE transition:
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder is negated if the dividend is negative.
- Width rules:
  - Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000.
  - The trial subtraction is 33-bit.
  - Overflow (0x80000000 / −1) gives lo=0x80000000 and hi=0 with no exception.
- Divide by zero: full latency, then lo=0xFFFFFFFF and hi=`srca` as sampled. No sign fixup is applied. No trap.
- `flush` high at an edge puts any state into IDLE. `hi`/`lo` keep their previous values and `result_valid` stays 0. `flush` beats `start` when both are high in IDLE.
- `reset` asynchronously clears the state to IDLE, the counter and all datapath registers to 0, and all outputs to 0.

## Timing
- `start` is first seen in IDLE at cycle T.
- BUSY occupies T+1..T+32; DONE is at T+33.
- `stall_div` is high for T..T+32 (33 cycles) and low at T+33.
- `result_valid`, `hi` and `lo` are valid at T+33. `hilowriteE` commits at that edge.
- A back-to-back divide entering E at T+34 is seen in IDLE at T+34. The throughput is one divide per 34 cycles.
- `busy` is high for exactly T+1..T+32.
- Reset mid-BUSY: outputs are 0 immediately (asynchronous). A new `start` is accepted on the first edge after `reset` deasserts.
- Flush at cycle F inside BUSY: the state is IDLE from F+1 and `stall_div` is 0 from F+1.

## Configuration
- `DIV_SIGNED_EN` defined: `signed_div` is honoured; magnitude conversion and sign fixup logic are present.
- `DIV_SIGNED_EN` undefined:
  - `signed_div` is ignored and every operation is treated as DIVU.
  - No negation logic is present.
  - 0xFFFFFFF9 / 2 gives lo=0x7FFFFFFC, hi=1.

## Test plan
- Unsigned: `start` with `signed_div`=0, srca=100, srcb=7 → `stall_div` high for 33 cycles; at T+33 lo=14, hi=2, `result_valid`=1 for one cycle.
- Signed (`DIV_SIGNED_EN`): srca=−7 (0xFFFFFFF9), srcb=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Check also srca=0x80000000, srcb=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: srca=0x12345678, srcb=0 → at T+33 lo=0xFFFFFFFF, hi=0x12345678; no early completion.
- Flush at T+10 with `start` still high → IDLE at T+11, `stall_div`=0 at T+11, `hi`/`lo` unchanged, no `result_valid` pulse. Then a fresh `start` at T+12 completes at T+45.
- Async `reset` pulse mid-BUSY (T+5, off-edge) → all outputs 0 before the next edge; after release, srca=9, srcb=3 gives lo=3, hi=0 at T'+33.
- Back-to-back divides: `start` held through DONE → no retrigger in DONE; the second divide is accepted at T+34 and completes at T+67.

Source files
------------

// File: rtl/exe_div_unit_if.sv
// Handshake/result bundle between the execute-stage pipeline register and the
// iterative divider; the pipeline side is master, the divider is slave.
interface exe_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             stall_div;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, signed_div, srca, srcb,
        input  stall_div, busy, result_valid, hi, lo
    );

    modport slave (
        input  flush, start, signed_div, srca, srcb,
        output stall_div, busy, result_valid, hi, lo
    );
endinterface

// File: rtl/exe_div_unit.sv
// Iterative restoring divider (one quotient bit per cycle) for the execute stage.
// Define DIV_SIGNED_EN to honour signed_div (DIV); otherwise every op is DIVU.
module exe_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    exe_div_unit_if.slave divIf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divStateT;

    divStateT         stateReg;
    divStateT         stateNext;
    logic [CNT_W-1:0] cntReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] dvsrReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             zeroDivReg;

    logic             loadEn;
    logic             stepEn;
    logic             finishEn;

    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             trialNeg;
    logic             unusedDiffMsb;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;

    logic [WIDTH-1:0] fixQuo;
    logic [WIDTH-1:0] fixRem;
    logic [WIDTH-1:0] hiFinal;
    logic [WIDTH-1:0] loFinal;

`ifdef DIV_SIGNED_EN
    logic signA;
    logic signB;
    logic negQuoReg;
    logic negRemReg;

    assign signA = divIf.signed_div & divIf.srca[WIDTH-1];
    assign signB = divIf.signed_div & divIf.srcb[WIDTH-1];
    // Two's-complement negation of 0x80000000 wraps to itself, which is the
    // correct unsigned magnitude.
    assign magA  = signA ? (~divIf.srca + 1'b1) : divIf.srca;
    assign magB  = signB ? (~divIf.srcb + 1'b1) : divIf.srcb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            negQuoReg <= 1'b0;
            negRemReg <= 1'b0;
        end else if (loadEn) begin
            negQuoReg <= signA ^ signB;
            negRemReg <= signA;
        end
    end

    assign fixQuo = negQuoReg ? (~stepQuo + 1'b1) : stepQuo;
    assign fixRem = negRemReg ? (~stepRem + 1'b1) : stepRem;
`else
    logic unusedSignedDiv;

    assign unusedSignedDiv = divIf.signed_div;
    assign magA   = divIf.srca;
    assign magB   = divIf.srcb;
    assign fixQuo = stepQuo;
    assign fixRem = stepRem;
`endif

    // Restoring step: shift {rem, quo} left, trial-subtract on the upper 33 bits.
    assign shifted = {remReg, quoReg[WIDTH-1]};
    assign {trialNeg, diff} = {1'b0, shifted} - {2'b00, dvsrReg};
    assign unusedDiffMsb = diff[WIDTH];
    assign stepRem = trialNeg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign stepQuo = {quoReg[WIDTH-2:0], ~trialNeg};

    // With a zero divisor every trial succeeds, so the remainder path ends up
    // holding the dividend magnitude; re-signing it returns srca unchanged.
    assign loFinal = zeroDivReg ? {WIDTH{1'b1}} : fixQuo;
    assign hiFinal = fixRem;

    always_comb begin
        loadEn   = 1'b0;
        stepEn   = 1'b0;
        finishEn = 1'b0;
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (divIf.start) begin
                    stateNext = BUSY;
                    loadEn    = !divIf.flush;
                end
            end
            BUSY: begin
                stepEn = !divIf.flush;
                if (cntReg == CNT_W'(1)) begin
                    stateNext = DONE;
                    finishEn  = !divIf.flush;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (divIf.flush) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntReg     <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            dvsrReg    <= '0;
            zeroDivReg <= 1'b0;
        end else if (loadEn) begin
            cntReg     <= CNT_W'(WIDTH);
            remReg     <= '0;
            quoReg     <= magA;
            dvsrReg    <= magB;
            zeroDivReg <= (divIf.srcb == '0);
        end else if (stepEn) begin
            cntReg <= cntReg - 1'b1;
            remReg <= stepRem;
            quoReg <= stepQuo;
        end
    end

    // Result registers only change on a completed divide; a flush leaves them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (finishEn) begin
            hiReg <= hiFinal;
            loReg <= loFinal;
        end
    end

    assign divIf.stall_div    = ((stateReg == IDLE) && divIf.start) || (stateReg == BUSY);
    assign divIf.busy         = (stateReg == BUSY);
    assign divIf.result_valid = (stateReg == DONE);
    assign divIf.hi           = hiReg;
    assign divIf.lo           = loReg;

endmodule

// File: tb/tb_exe_div_unit.sv
// Randomized bench for exe_div_unit against a plain-arithmetic quotient/remainder
// model, plus directed flush, async reset, divide-by-zero and back-to-back cases.
module tb_exe_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    int          vecCount = 0;
    int          errCount = 0;
    logic [31:0] lastQ = '0;
    logic [31:0] lastR = '0;

    exe_div_unit_if #(.WIDTH(32)) divIf ();

    exe_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .divIf (divIf)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic sd,
                                   output logic [31:0] q, output logic [31:0] r);
        logic   s;
        longint sa, sb, sq, sr;
        s = sd;
`ifndef DIV_SIGNED_EN
        s = 1'b0;
`endif
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end
    endfunction

    // Call just after a rising edge with the divider idle; returns just after
    // the rising edge that starts cycle T+34.
    task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic sd, input bit hold);
        logic [31:0] q, r;
        int stallN = 0;
        int busyN  = 0;
        int rvN    = 0;
        refDiv(a, b, sd, q, r);
        divIf.start      = 1'b1;
        divIf.srca       = a;
        divIf.srcb       = b;
        divIf.signed_div = sd;
        for (int c = 0; c < 33; c++) begin
            @(negedge clk);
            stallN += int'(divIf.stall_div);
            busyN  += int'(divIf.busy);
            rvN    += int'(divIf.result_valid);
            if (c == 1 && !hold) begin
                divIf.srca       = $urandom;
                divIf.srcb       = $urandom;
                divIf.signed_div = ~sd;
            end
        end
        @(negedge clk);
        checkVal("stall_cycles", 64'(stallN), 64'd33);
        checkVal("busy_cycles", 64'(busyN), 64'd32);
        checkVal("early_valid", 64'(rvN), 64'd0);
        checkVal("result_valid", 64'(divIf.result_valid), 64'd1);
        checkVal("stall_in_done", 64'(divIf.stall_div), 64'd0);
        checkVal("lo", 64'(divIf.lo), 64'(q));
        checkVal("hi", 64'(divIf.hi), 64'(r));
        $display("div a=0x%08h b=0x%08h sd=%0d -> lo=0x%08h hi=0x%08h", a, b, sd, divIf.lo, divIf.hi);
        lastQ = q;
        lastR = r;
        @(posedge clk);
        #1;
        if (!hold) begin
            divIf.start = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        sd;
        reset            = 1'b1;
        divIf.flush      = 1'b0;
        divIf.start      = 1'b0;
        divIf.signed_div = 1'b0;
        divIf.srca       = '0;
        divIf.srcb       = '0;
        #12;
        checkVal("rst_stall", 64'(divIf.stall_div), 64'd0);
        checkVal("rst_busy", 64'(divIf.busy), 64'd0);
        checkVal("rst_valid", 64'(divIf.result_valid), 64'd0);
        checkVal("rst_hi", 64'(divIf.hi), 64'd0);
        checkVal("rst_lo", 64'(divIf.lo), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        doDiv(32'd100, 32'd7, 1'b0, 1'b0);
        doDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        doDiv(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        doDiv(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);
        // Back-to-back with start held through DONE.
        doDiv(32'd100, 32'd7, 1'b0, 1'b1);
        doDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            sd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2, 3: b = 32'($urandom_range(1, 255));
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            doDiv(a, b, sd, $urandom_range(0, 3) == 0);
        end
        divIf.start = 1'b0;
        @(posedge clk);
        #1;

        // Flush at T+10 with start high; idle and unchanged results at T+11.
        divIf.start      = 1'b1;
        divIf.srca       = 32'd1000;
        divIf.srcb       = 32'd3;
        divIf.signed_div = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        divIf.flush = 1'b1;
        @(posedge clk);
        #1;
        divIf.flush = 1'b0;
        divIf.start = 1'b0;
        @(negedge clk);
        checkVal("flush_stall", 64'(divIf.stall_div), 64'd0);
        checkVal("flush_busy", 64'(divIf.busy), 64'd0);
        checkVal("flush_valid", 64'(divIf.result_valid), 64'd0);
        checkVal("flush_hi", 64'(divIf.hi), 64'(lastR));
        checkVal("flush_lo", 64'(divIf.lo), 64'(lastQ));
        @(posedge clk);
        #1;
        doDiv(32'd1000, 32'd3, 1'b0, 1'b0);

        // Asynchronous reset pulse mid-BUSY, off the clock edge.
        divIf.start = 1'b1;
        divIf.srca  = 32'hDEAD_BEEF;
        divIf.srcb  = 32'd5;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
        end
        #2;
        reset       = 1'b1;
        divIf.start = 1'b0;
        #1;
        checkVal("arst_stall", 64'(divIf.stall_div), 64'd0);
        checkVal("arst_busy", 64'(divIf.busy), 64'd0);
        checkVal("arst_valid", 64'(divIf.result_valid), 64'd0);
        checkVal("arst_hi", 64'(divIf.hi), 64'd0);
        checkVal("arst_lo", 64'(divIf.lo), 64'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        doDiv(32'd9, 32'd3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
